// File: rtl/uart_rx_fifo.sv
// UART receiver (5-9 data bits, optional even/odd parity, runtime baud divisor)
// feeding a first-word-fall-through receive FIFO whose entries carry error flags.
module uart_rx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int BAUD_W     = 13,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          RX,
   input  logic [BAUD_W-1:0]             baud_div,
   input  logic                          parity_en,
   input  logic                          parity_odd,
   input  logic                          rd_en,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_valid,
   output logic                          parity_err,
   output logic                          frame_err,
   output logic                          overrun,
   input  logic                          clr_overrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = DATA_BITS + 2;
   localparam logic [BAUD_W-1:0] ONE      = BAUD_W'(1);
   localparam logic [3:0]        LAST_BIT = 4'(DATA_BITS - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

   logic                 rx_meta_q, rxs_q;
   state_t               state_q;
   logic [BAUD_W-1:0]    timer_q, div_q;
   logic                 par_en_q, par_odd_q, pe_q;
   logic [3:0]           bit_cnt_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 push_q;
   logic [ENT_W-1:0]     push_word_q;
   logic                 sample;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rxs_q     <= 1'b1;
      end else begin
         rx_meta_q <= RX;
         rxs_q     <= rx_meta_q;
      end
   end

   assign sample = (timer_q == '0);

   // Frame format and divisor are captured at start detection so that
   // register writes mid-frame only affect the following frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         timer_q     <= '0;
         div_q       <= '0;
         par_en_q    <= 1'b0;
         par_odd_q   <= 1'b0;
         pe_q        <= 1'b0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         push_q      <= 1'b0;
         push_word_q <= '0;
      end else begin
         push_q <= 1'b0;
         if (state_q != IDLE && state_q != BRK_WAIT)
            timer_q <= sample ? div_q - ONE : timer_q - ONE;
         case (state_q)
            IDLE: begin
               if (!rxs_q) begin
                  state_q   <= START;
                  timer_q   <= (baud_div >> 1) - ONE;
                  div_q     <= baud_div;
                  par_en_q  <= parity_en;
                  par_odd_q <= parity_odd;
                  pe_q      <= 1'b0;
               end
            end
            START: begin
               if (sample) begin
                  if (rxs_q) begin
                     state_q <= IDLE;
                  end else begin
                     state_q   <= DATA;
                     bit_cnt_q <= '0;
                  end
               end
            end
            DATA: begin
               if (sample) begin
                  shift_q   <= {rxs_q, shift_q[DATA_BITS-1:1]};
                  bit_cnt_q <= bit_cnt_q + 4'd1;
                  if (bit_cnt_q == LAST_BIT)
                     state_q <= par_en_q ? PARITY : STOP;
               end
            end
            PARITY: begin
               if (sample) begin
                  pe_q    <= ((^shift_q) ^ rxs_q) != par_odd_q;
                  state_q <= STOP;
               end
            end
            STOP: begin
               if (sample) begin
                  push_q      <= 1'b1;
                  push_word_q <= {~rxs_q, pe_q, shift_q};
                  state_q     <= rxs_q ? IDLE : BRK_WAIT;
               end
            end
            BRK_WAIT: begin
               // A line held low (break) must not be reread as back-to-back frames.
               if (rxs_q)
                  state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] cnt_q;
   logic             overrun_q;
   logic             pop, full, wr_en;
   logic [ENT_W-1:0] head;

   assign pop   = rd_en && (cnt_q != '0);
   assign full  = (cnt_q == FULL_CNT);
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign wr_en = push_q && (!full || pop);

   always_ff @(posedge clk) begin
      if (wr_en)
         mem_q[wr_ptr_q] <= push_word_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (wr_en)
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop)
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (wr_en && !pop)
            cnt_q <= cnt_q + CNT_W'(1);
         else if (pop && !wr_en)
            cnt_q <= cnt_q - CNT_W'(1);
         if (push_q && full && !pop)
            overrun_q <= 1'b1;
         else if (clr_overrun)
            overrun_q <= 1'b0;
      end
   end

   // Head fields are forced to zero while empty so stale RAM never shows.
   assign head       = mem_q[rd_ptr_q];
   assign rx_valid   = (cnt_q != '0);
   assign rx_data    = rx_valid ? head[DATA_BITS-1:0] : '0;
   assign parity_err = rx_valid & head[DATA_BITS];
   assign frame_err  = rx_valid & head[DATA_BITS+1];
   assign overrun    = overrun_q;
   assign fifo_cnt   = cnt_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: randomized serial frames against a
// frame-level reference model, with a monitor that drains and compares the FIFO.
module tb_uart_rx_fifo;
   localparam int DB    = 8;
   localparam int BW    = 13;
   localparam int DEPTH = 8;

   logic          clk         = 1'b0;
   logic          rst_n       = 1'b0;
   logic          RX          = 1'b1;
   logic [BW-1:0] baud_div    = 13'd16;
   logic          parity_en   = 1'b0;
   logic          parity_odd  = 1'b0;
   logic          rd_en       = 1'b0;
   logic          clr_overrun = 1'b0;
   logic [DB-1:0] rx_data;
   logic          rx_valid, parity_err, frame_err, overrun;
   logic [$clog2(DEPTH):0] fifo_cnt;

   int checks = 0;
   int passed = 0;
   logic [DB+1:0] exp_q[$];
   logic [DB+1:0] mon_e;
   bit reader_on = 1'b0;
   bit force_rd  = 1'b0;
   bit exp_ovr   = 1'b0;

   uart_rx_fifo #(.DATA_BITS(DB), .BAUD_W(BW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .RX(RX), .baud_div(baud_div),
      .parity_en(parity_en), .parity_odd(parity_odd), .rd_en(rd_en),
      .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
      .frame_err(frame_err), .overrun(overrun), .clr_overrun(clr_overrun),
      .fifo_cnt(fifo_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h required %0h", name, act, req);
   endtask

   // Monitor: whenever reading is enabled and a word is presented, pop it and
   // compare {frame_err, parity_err, rx_data} with the scoreboard front.
   initial begin
      forever begin
         @(negedge clk);
         if (rx_valid === 1'b1 && (reader_on || force_rd)) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_word: got %0h required no word", {frame_err, parity_err, rx_data});
            end else begin
               mon_e = exp_q.pop_front();
               check("rx_word", {frame_err, parity_err, rx_data}, mon_e);
               $display("word %0h (fe=%0b pe=%0b)", rx_data, frame_err, parity_err);
            end
            rd_en = 1'b1;
         end else begin
            rd_en = 1'b0;
         end
      end
   end

   // Drives one frame; the expected entry is queued as the stop bit begins.
   // pop_at_push raises a one-cycle pop exactly when the DUT pushes the word.
   task automatic send_frame(input logic [DB-1:0] data, input bit pen, input bit podd,
                             input bit pbit, input bit stopb, input int div, input bit pop_at_push);
      logic pe;
      int   h;
      baud_div = BW'(div); parity_en = pen; parity_odd = podd;
      @(posedge clk); #1;
      RX = 1'b0;
      repeat (div) @(posedge clk);
      #1;
      baud_div   = BW'($urandom_range(40, 4));
      parity_en  = 1'($urandom_range(1, 0));
      parity_odd = 1'($urandom_range(1, 0));
      for (int b = 0; b < DB; b++) begin
         RX = data[b];
         repeat (div) @(posedge clk);
         #1;
      end
      if (pen) begin
         RX = pbit;
         repeat (div) @(posedge clk);
         #1;
      end
      pe = pen && ((($countones(data) + int'(pbit)) % 2) != int'(podd));
      if (exp_q.size() < DEPTH || pop_at_push) exp_q.push_back({~stopb, pe, data});
      else exp_ovr = 1'b1;
      $display("send %0h pen=%0b odd=%0b pbit=%0b stop=%0b div=%0d", data, pen, podd, pbit, stopb, div);
      RX = stopb;
      h = div / 2 - 1;
      for (int i = 0; i < div; i++) begin
         if (pop_at_push) force_rd = (i == h + 4);
         @(posedge clk);
         #1;
      end
      force_rd = 1'b0;
   endtask

   task automatic frame(input logic [DB-1:0] data, input bit pen, input bit podd,
                        input bit pbit, input bit stopb, input int div, input bit pop_at_push);
      send_frame(data, pen, podd, pbit, stopb, div, pop_at_push);
      RX = 1'b1;
      repeat (2 * div + 4) @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_rx_valid", rx_valid, 0);
      check("rst_fifo_cnt", fifo_cnt, 0);
      check("rst_overrun", overrun, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_parity_err", parity_err, 0);
      check("rst_frame_err", frame_err, 0);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      frame(8'hA5, 0, 0, 0, 1, 16, 0);
      check("a5_cnt", fifo_cnt, 1);
      check("a5_valid", rx_valid, 1);
      check("a5_head", {frame_err, parity_err, rx_data}, 10'h0A5);
      reader_on = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      check("a5_popped", rx_valid, 0);

      frame(8'h03, 1, 0, 1, 1, 16, 0);
      frame(8'h03, 1, 0, 0, 1, 16, 0);
      frame(8'h03, 1, 1, 1, 1, 16, 0);
      frame(8'h03, 1, 1, 0, 1, 16, 0);

      for (int n = 0; n < 24; n++)
         frame(8'($urandom), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
               1'($urandom_range(1, 0)), $urandom_range(3, 0) != 0,
               int'($urandom_range(24, 4)), 0);
      repeat (20) @(posedge clk);
      #1;
      check("random_drained", exp_q.size(), 0);
      check("random_cnt", fifo_cnt, 0);

      // Broken stop bit followed by a long break: one word, nothing more.
      send_frame(8'h5A, 0, 0, 0, 0, 16, 0);
      repeat (20 * 16) @(posedge clk);
      #1;
      RX = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      check("break_drained", exp_q.size(), 0);
      check("break_cnt", fifo_cnt, 0);

      baud_div = 13'd16; parity_en = 1'b0;
      @(posedge clk); #1;
      RX = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      RX = 1'b1;
      repeat (80) @(posedge clk);
      #1;
      check("false_start_cnt", fifo_cnt, 0);
      check("false_start_valid", rx_valid, 0);

      reader_on = 1'b0;
      for (int n = 0; n < DEPTH + 1; n++) frame(8'(n * 17 + 1), 0, 0, 0, 1, 16, 0);
      check("ovf_cnt", fifo_cnt, exp_q.size());
      check("ovf_overrun", overrun, exp_ovr);
      check("ovf_head", {frame_err, parity_err, rx_data}, exp_q[0]);
      reader_on = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      check("ovf_drained_cnt", fifo_cnt, 0);
      check("ovf_sticky", overrun, exp_ovr);
      clr_overrun = 1'b1;
      @(posedge clk); #1;
      clr_overrun = 1'b0;
      exp_ovr = 1'b0;
      check("ovf_cleared", overrun, exp_ovr);

      reader_on = 1'b0;
      for (int n = 0; n < DEPTH; n++) frame(8'($urandom), 0, 0, 0, 1, 16, 0);
      frame(8'hC3, 0, 0, 0, 1, 16, 1);
      check("full_pop_cnt", fifo_cnt, exp_q.size());
      check("full_pop_overrun", overrun, exp_ovr);
      frame(8'h3C, 0, 0, 0, 1, 16, 0);
      check("full_drop_overrun", overrun, exp_ovr);

      // Reset in the middle of a frame with a full FIFO and overrun set.
      baud_div = 13'd16;
      @(posedge clk); #1;
      RX = 1'b0;
      repeat (16 * 4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      exp_q.delete();
      exp_ovr = 1'b0;
      check("midrst_valid", rx_valid, 0);
      check("midrst_cnt", fifo_cnt, 0);
      check("midrst_overrun", overrun, exp_ovr);
      check("midrst_data", rx_data, 0);
      check("midrst_flags", {frame_err, parity_err}, 0);
      RX = 1'b1;
      reader_on = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (200) @(posedge clk);
      #1;
      check("midrst_no_push", fifo_cnt, 0);
      frame(8'h96, 1, 1, 0, 1, 12, 0);
      repeat (10) @(posedge clk);
      #1;
      check("final_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver with a configurable frame format and a receive FIFO. It supports 5-9 data bits, optional even/odd parity, a runtime baud divisor, false-start rejection, and framing/parity/overrun error reporting. The block sits between the board RX pin and the CPU memory-mapped I/O. The CPU drains received words through a first-word-fall-through FIFO instead of a single ready flag.

Parameters:
DATA_BITS, 8, data bits per frame (5..9)
BAUD_W, 13, width of baud divisor
FIFO_DEPTH, 8, receive FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
RX  in  1  asynchronous serial input, idle high
baud_div  in  BAUD_W  clocks per bit; must be >=4
parity_en  in  1  1 = expect parity bit after data
parity_odd  in  1  1 = odd parity, 0 = even
rd_en  in  1  pop FIFO head this cycle
rx_data  out  DATA_BITS  FIFO head data (valid when rx_valid)
rx_valid  out  1  FIFO not empty
parity_err  out  1  parity error flag of the head entry
frame_err  out  1  stop-bit error flag of the head entry
overrun  out  1  sticky: a word was dropped because the FIFO was full
clr_overrun  in  1  clears overrun
fifo_cnt  out  $clog2(FIFO_DEPTH)+1  entries held

Behaviour:
- Reset values: rx_valid=0, fifo_cnt=0, overrun=0, rx_data/parity_err/frame_err=0. The FIFO pointers clear, state=IDLE, and both RX sync flops reset to 1.
- RX passes through 2 flops (rxs). All decisions use rxs only.
- baud_div, parity_en, and parity_odd are latched on start detection. Changes mid-frame take effect on the next frame only.
- Bit timer: on start it loads (baud_div>>1)-1. On each sample it reloads latched_div-1, otherwise it decrements. A sample occurs when the timer reaches 0.
- States:
  - IDLE: rxs==0 -> START and start the timer.
  - START: at sample, rxs==1 -> IDLE (false start, nothing pushed). Otherwise -> DATA with bit_cnt=0.
  - DATA: each sample shifts rxs in LSB-first and increments bit_cnt. After DATA_BITS samples -> PARITY if parity_en, else -> STOP.
  - PARITY: at sample, pe = (XOR of data bits XOR rxs) != parity_odd. Then -> STOP.
  - STOP: at sample, fe = ~rxs and the entry {fe, pe, data} is pushed. Then -> IDLE if rxs==1, else -> BRK_WAIT.
  - BRK_WAIT: stay until rxs==1, then -> IDLE. This prevents a held-low line from being reread as repeated frames.
- pe=0 when parity is disabled.
- Push happens in the cycle after the stop sample. The word is visible at rx_data with rx_valid=1 on the following cycle.
- Pop: rd_en && rx_valid advances the head. rd_en while empty is ignored with no pointer change.
- Simultaneous push and pop: both occur and fifo_cnt is unchanged. This applies when full too: pop frees the slot, so there is no overrun.
- Push while full without pop: the new word is dropped, overrun is set, and FIFO contents are unchanged.
- overrun clears on clr_overrun. If a set and clear occur in the same cycle, set wins.
- Pointers wrap modulo FIFO_DEPTH. fifo_cnt ranges 0..FIFO_DEPTH.
- Asynchronous reset mid-frame aborts the frame, empties the FIFO, and returns to IDLE. No partial word is pushed.
- Frame length in samples: 1 + DATA_BITS + parity_en + 1.

Test Plan:
- baud_div=16, 8N1, send 0xA5 -> one entry: rx_data=0xA5, pe=0, fe=0, fifo_cnt=1. rd_en for 1 cycle -> rx_valid=0.
- parity_en=1, parity_odd=0, send 0x03 with parity bit 1 -> pe=1. Resend with parity bit 0 -> pe=0. Repeat with odd parity and the inverse expectations.
- Stop bit driven 0, then line held low 20 bit times, then released -> exactly one entry with fe=1. No further entries until a new start bit.
- RX low pulse of 4 clocks at baud_div=16 -> false start, fifo_cnt stays 0.
- FIFO_DEPTH=8: send 9 frames with no reads -> fifo_cnt=8, overrun=1, and the head holds the first byte. Then pop all 8 in order. Then clr_overrun -> overrun=0.
- Full FIFO, rd_en asserted in the same cycle as the 9th push -> fifo_cnt stays 8, overrun=0. Also assert rst_n low mid-frame -> all outputs at reset values, no push.
